enable_table_loader: RTL
========================

ENABLE_TABLE_LOADER -- requirements
Module: enable_table_loader

Interface
REQ-001 SHALL have parameter CONFIG_BITS, default 4: number of selectable memory-map configurations is 2**CONFIG_BITS.
REQ-002 SHALL have parameter AUTOLOAD, default 1: when 1, load configuration 0 automatically after reset release.
REQ-003 SHALL have port fpga_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port config_sel  input  CONFIG_BITS  configuration to load, latched when start is accepted.
REQ-007 SHALL have port src_addr  output  CONFIG_BITS+7  byte address into configuration store, {config, byte_index[6:0]}.
REQ-008 SHALL have port src_rd  output  1  read strobe to configuration store.
REQ-009 SHALL have port src_data  input  8  store read data, valid exactly one cycle after src_rd.
REQ-010 SHALL have port table_we  output  1  enable-table write strobe to the downstream enable stage.
REQ-011 SHALL have port table_val  output  2  entry value: bit1 = RAM enable, bit0 = bus enable.
REQ-012 SHALL have port table_write_addr  output  9  entry index: bit8 = rwbar, bits7:0 = address[15:8] page.
REQ-013 SHALL have port busy  output  1  high from accepted start until DONE completes.
REQ-014 SHALL have port cpu_halt  output  1  equals busy; holds target CPU off the bus during a load.
REQ-015 SHALL have port done  output  1  one-cycle pulse on load completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, WRITE, DONE; all outputs registered.
REQ-017 IDLE: on start=1 (or first cycle after reset release when AUTOLOAD=1, using config 0) SHALL latch config, clear byte_index and entry counter, go FETCH.
REQ-018 FETCH (1 cycle): src_rd=1, src_addr={config, byte_index}; next state WAIT.
REQ-019 WAIT (1 cycle): src_rd=0; capture src_data into byte register at end of cycle; next WRITE.
REQ-020 WRITE (4 cycles, sub-count k=0..3): table_we=1, table_val=byte[2k+1:2k] (LSB pair first), table_write_addr={byte_index, k}.
REQ-021 After k=3: if byte_index=127 go DONE, else increment byte_index, go FETCH.
REQ-022 Each byte costs exactly 6 cycles; full load = 128 bytes = 512 writes, 768 cycles from first FETCH to DONE.
REQ-023 DONE (1 cycle): done=1, busy stays 1; next IDLE with busy=0.
REQ-024 table_we SHALL be 0 in every state except WRITE; table_write_addr SHALL never wrap past 511.
REQ-025 start while busy SHALL be ignored (not queued); config_sel changes during a load SHALL have no effect.
REQ-026 start and DONE in same cycle: start ignored; a new start is accepted only in IDLE.

Reset
REQ-027 On reset=1: state IDLE, table_we=0, table_val=0, table_write_addr=0, src_rd=0, src_addr=0, busy=0, cpu_halt=0, done=0.
REQ-028 Reset mid-load SHALL abort in the next cycle with no further writes; the partially written table is not restored.
REQ-029 AUTOLOAD trigger SHALL fire once per reset release, not on every IDLE entry.

Structure
REQ-030 Shared package holds: state encoding, BYTES_PER_CONFIG=128, ENTRIES_PER_BYTE=4, TABLE_ENTRIES=512, table_val bit positions (RAM=1, BUS=0).
REQ-031 Single module, no sub-modules; the configuration store and downstream enable stage are external.

Verification
REQ-032 AUTOLOAD=1, reset released, store config0 byte0=0xE4 -> writes addr0..3 values 0,1,2,3; done after 768 cycles; busy/cpu_halt high throughout.
REQ-033 start with config_sel=5 -> first src_addr=0x280, last src_addr=0x2FF; final write table_write_addr=511.
REQ-034 start pulsed again at cycle 100 of a load with config_sel=2 -> ignored; src_addr stays in config 5 range; exactly 512 writes.
REQ-035 reset asserted at cycle 300 of load -> table_we=0 next cycle, all outputs at reset values, no done pulse.
REQ-036 start asserted in DONE cycle -> ignored; start in following IDLE cycle -> new load begins, FETCH next cycle.
REQ-037 Scoreboard: model the downstream table, compare all 512 entries against store contents after done.

Source files
------------

// File: rtl/enable_table_loader_pkg.sv
// rtl/enable_table_loader_pkg.sv - shared constants, state encoding and entry helper for the enable-table loader
package enable_table_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int BYTES_PER_CONFIG = 128;
    localparam int ENTRIES_PER_BYTE = 4;
    localparam int TABLE_ENTRIES    = 512;
    localparam int BYTE_INDEX_BITS  = 7;
    localparam int SUB_BITS         = 2;
    localparam int TABLE_ADDR_BITS  = 9;
    localparam int TV_RAM_BIT       = 1;
    localparam int TV_BUS_BIT       = 0;

    // Entry k of a store byte lives in bits [2k+1:2k]; the odd bit is the RAM enable.
    function automatic logic [1:0] entry_val(input logic [7:0] store_byte, input logic [1:0] k);
        logic [1:0] v;
        v             = '0;
        v[TV_BUS_BIT] = store_byte[{k, 1'b0}];
        v[TV_RAM_BIT] = store_byte[{k, 1'b1}];
        return v;
    endfunction

endpackage

// File: rtl/enable_table_loader_if.sv
// rtl/enable_table_loader_if.sv - configuration-store read port and enable-table write port
interface enable_table_loader_if
    import enable_table_loader_pkg::*;
#(
    parameter int CONFIG_BITS = 4
);
    logic [CONFIG_BITS+BYTE_INDEX_BITS-1:0] src_addr;
    logic                                   src_rd;
    logic [7:0]                             src_data;
    logic                                   table_we;
    logic [1:0]                             table_val;
    logic [TABLE_ADDR_BITS-1:0]             table_write_addr;

    modport master (
        output src_addr,
        output src_rd,
        input  src_data,
        output table_we,
        output table_val,
        output table_write_addr
    );

    modport slave (
        input  src_addr,
        input  src_rd,
        output src_data,
        input  table_we,
        input  table_val,
        input  table_write_addr
    );

endinterface

// File: rtl/enable_table_loader.sv
// rtl/enable_table_loader.sv - streams one 128-byte configuration into the 512-entry memory-map enable table
module enable_table_loader
    import enable_table_loader_pkg::*;
#(
    parameter int CONFIG_BITS = 4,
    parameter bit AUTOLOAD    = 1'b1
) (
    input  logic                   fpga_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CONFIG_BITS-1:0] config_sel,
    output logic                   busy,
    output logic                   cpu_halt,
    output logic                   done,
    enable_table_loader_if.master  bus
);

    localparam logic [BYTE_INDEX_BITS-1:0] LAST_BYTE = BYTE_INDEX_BITS'(BYTES_PER_CONFIG - 1);
    localparam logic [SUB_BITS-1:0]        LAST_SUB  = SUB_BITS'(ENTRIES_PER_BYTE - 1);

    state_t                     state;
    logic [CONFIG_BITS-1:0]     cfg;
    logic [BYTE_INDEX_BITS-1:0] byte_index;
    logic [SUB_BITS-1:0]        sub_k;
    logic [7:0]                 byte_reg;
    logic                       autoload_pending;
    logic [CONFIG_BITS-1:0]     launch_cfg;

    // The post-reset autoload always uses configuration 0, even if start is also high.
    always_comb begin
        launch_cfg = autoload_pending ? '0 : config_sel;
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state                <= S_IDLE;
            cfg                  <= '0;
            byte_index           <= '0;
            sub_k                <= '0;
            byte_reg             <= '0;
            autoload_pending     <= AUTOLOAD;
            busy                 <= 1'b0;
            cpu_halt             <= 1'b0;
            done                 <= 1'b0;
            bus.src_rd           <= 1'b0;
            bus.src_addr         <= '0;
            bus.table_we         <= 1'b0;
            bus.table_val        <= '0;
            bus.table_write_addr <= '0;
        end else begin
            bus.src_rd   <= 1'b0;
            bus.table_we <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || autoload_pending) begin
                        cfg              <= launch_cfg;
                        byte_index       <= '0;
                        sub_k            <= '0;
                        autoload_pending <= 1'b0;
                        busy             <= 1'b1;
                        cpu_halt         <= 1'b1;
                        bus.src_rd       <= 1'b1;
                        bus.src_addr     <= {launch_cfg, {BYTE_INDEX_BITS{1'b0}}};
                        state            <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Store data is only valid now, so the first entry comes straight from it.
                    byte_reg             <= bus.src_data;
                    sub_k                <= '0;
                    bus.table_we         <= 1'b1;
                    bus.table_val        <= entry_val(bus.src_data, 2'd0);
                    bus.table_write_addr <= {byte_index, 2'd0};
                    state                <= S_WRITE;
                end
                S_WRITE: begin
                    if (sub_k == LAST_SUB) begin
                        if (byte_index == LAST_BYTE) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            byte_index   <= byte_index + 7'd1;
                            bus.src_rd   <= 1'b1;
                            bus.src_addr <= {cfg, byte_index + 7'd1};
                            state        <= S_FETCH;
                        end
                    end else begin
                        sub_k                <= sub_k + 2'd1;
                        bus.table_we         <= 1'b1;
                        bus.table_val        <= entry_val(byte_reg, sub_k + 2'd1);
                        bus.table_write_addr <= {byte_index, sub_k + 2'd1};
                    end
                end
                S_DONE: begin
                    busy     <= 1'b0;
                    cpu_halt <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
